data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface. It serves the processor's load/store requests over a req/ack handshake.
- Holds a 16-bit-wide data store and inserts a configurable number of wait states per access.
- Sits between the processor's address/dataout/write outputs and its memout input, replacing the fixed-latency RAM macro.
- Lets the processor be tested against slow memory.

Parameters:
- DATA_W, 16, data word width (processor bus width).
- ADDR_W, 7, address width taken from the processor address bus.
- DEPTH, 128, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- WAIT_STATES, 2, idle cycles inserted between request capture and response; range 0..15.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  processor access request; held high until ack is seen.
- write  input  1  1 = store, 0 = load; sampled with req.
- address  input  ADDR_W  word address; sampled with req.
- dataout  input  DATA_W  store data from the processor; sampled with req.
- memout  output  DATA_W  load data returned to the processor; valid in the ack cycle and held afterwards.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from request capture until the ack cycle inclusive.
- err  output  1  one-cycle pulse coincident with ack when the address is >= DEPTH.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - memout = 0, ack = 0, busy = 0, err = 0.
  - Wait counter = 0; captured request registers = 0.
  - Store contents are NOT cleared and are undefined after power-up.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When req = 1, capture address, dataout and write.
  - Then go to WAIT if WAIT_STATES > 0, else go to RESP.
  - busy rises in the cycle after capture.
- WAIT:
  - The counter loads WAIT_STATES - 1 on entry and decrements each cycle.
  - At 0 the FSM goes to RESP.
  - No input is sampled in this state.
- RESP (one cycle):
  - ack = 1, and err = 1 if the address is out of range.
  - Store in range: array[address] <= captured data; memout is unchanged.
  - Load in range: memout <= array[address], registered so it is visible in the ack cycle.
  - Load out of range: memout <= 0.
  - Store out of range: dropped.
  - Next state is IDLE.
- Latency: ack is asserted exactly WAIT_STATES + 2 cycles after the req capture edge; a new request is accepted in the first IDLE cycle after ack.
- Back-to-back: if req is still high in the IDLE cycle after ack, that is a new request. The processor must drop req within the ack cycle when it has no further access.
- req dropped before ack: a captured access still completes and still pulses ack. No abort mechanism.
- Read-after-write: a load issued after a store's ack returns the stored value.
- Reset asserted mid-access: the access is aborted, no array write occurs, no ack is produced.
- memout holds the last load result through stores and idle cycles.

Decomposition:
- Shared package data_mem_pkg contains:
  - The state enum {IDLE, WAIT, RESP}.
  - The DATA_W and ADDR_W defaults.
  - The wait-counter width (4 bits).
- Sub-module data_mem_array: DEPTH x DATA_W synchronous single-port store with write enable, plus a registered read port. It has no reset on contents.
- The FSM, counter and range check stay in data_mem_responder.

Test Plan:
- Reset behaviour: assert reset low mid-WAIT (WAIT_STATES = 2) -> memout = 0, ack = 0, busy = 0 immediately. After release, a load of the aborted store's address returns the prior value.
- Store then load: store address 7'h05, data 16'hBEEF, then load address 7'h05 -> ack 4 cycles after each capture, memout = 16'hBEEF in the load's ack cycle, err = 0.
- Zero wait states: WAIT_STATES = 0, load address 7'h00 -> ack exactly 2 cycles after capture; busy high for exactly 2 cycles.
- Back-to-back with early drop: hold req through ack for 3 consecutive stores to addresses 1, 2, 3 (data 16'h0011, 16'h0022, 16'h0033), with req dropped one cycle after the 3rd capture -> exactly 3 ack pulses. Reads afterwards return 16'h0011, 16'h0022, 16'h0033.
- Out-of-range: DEPTH = 64, store 16'h1234 to address 7'h50, then load 7'h50 -> err pulses with both acks, load memout = 16'h0000, array words 0..63 unchanged.
- Hold behaviour: after a load returning 16'hBEEF, perform a store of 16'h0001 to address 7'h06 -> memout stays 16'hBEEF through and after that store's ack.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
package data_mem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 7;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W single-port store with write enable and a registered read port.
// Contents are never reset.
module data_mem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 128,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clock,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory interface: req/ack handshake,
// configurable wait states, range check and held load data.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DEPTH       = 128,
   parameter int WAIT_STATES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataout,
   output logic [DATA_W-1:0] memout,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   memout_q, memout_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                in_range;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_rdata;

   assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

   // Read address follows addr_d so the registered read already holds the
   // captured word when RESP is reached, even with zero wait states.
   data_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock (clock),
      .we    (mem_we),
      .addr  (addr_d[IDX_W-1:0]),
      .wdata (data_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      write_d  = write_q;
      memout_d = memout_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy_q;
      mem_we   = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            // The ack cycle is spent in IDLE; req is only honoured after it.
            if (req && !ack_q) begin
               addr_d  = address;
               data_d  = dataout;
               write_d = write;
               busy_d  = 1'b1;
               cnt_d   = WAIT_LD;
               state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            busy_d  = 1'b1;
            ack_d   = 1'b1;
            err_d   = !in_range;
            state_d = IDLE;
            if (in_range) begin
               if (write_q) begin
                  mem_we = 1'b1;
               end else begin
                  memout_d = mem_rdata;
               end
            end else if (!write_q) begin
               memout_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
         memout_q <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         write_q  <= write_d;
         memout_q <= memout_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign memout = memout_q;
   assign ack    = ack_q;
   assign busy   = busy_q;
   assign err    = err_q;

endmodule
